gs_mem_arb: RTL and testbench
=============================

# gs_mem_arb

Arbiter and sequencer for the General Sound (GS) external memory port of the TSConf MiST top level. It shares one byte-wide memory request/acknowledge port between two requesters: the GS Z80 memory interface (`gs_mem_*` signals of the `tsconf` core) and the `data_io` loader, which preloads GS RAM. It also applies the GS memory-size mask: reads outside the selected size return 0xFF and writes there are dropped without a memory cycle. The block drives `GS_WAIT` through `gs_ready`.

## Interface
Parameters:
- `ADDR_W`, default 21: byte address width (2 MB).
- `LD_FIFO_DEPTH`, default 4: loader write FIFO entries; must be a power of 2, ≥2.

Ports:
- `clk_sys`  in  1  system clock; all logic on its rising edge.
- `reset`  in  1  synchronous, active-high.
- `mem_size`  in  2  GS size select: 0 = 512 KB, 1 = 1 MB, 2/3 = 2 MB.
- `gs_addr`  in  ADDR_W  GS byte address.
- `gs_din`  in  8  GS write data.
- `gs_rd`  in  1  GS read request (level).
- `gs_wr`  in  1  GS write request (level); `gs_rd` and `gs_wr` are never both high.
- `gs_dout`  out  8  GS read data, valid while `gs_ready` is high after a read.
- `gs_ready`  out  1  GS access complete or idle; `GS_WAIT` = `~gs_ready`.
- `ld_wr`  in  1  loader write strobe, one cycle per byte, no backpressure.
- `ld_addr`  in  ADDR_W  loader byte address.
- `ld_data`  in  8  loader byte.
- `ld_overflow`  out  1  sticky: a loader write was dropped.
- `mem_req`  out  1  memory request, held until acknowledged.
- `mem_we`  out  1  1 = write, 0 = read; stable while `mem_req` is high.
- `mem_addr`  out  ADDR_W  address; stable while `mem_req` is high.
- `mem_wdata`  out  8  write data; stable while `mem_req` is high.
- `mem_rdata`  in  8  read data, valid in the `mem_ack` cycle.
- `mem_ack`  in  1  one-cycle completion pulse.

## Operation
- **Reset values:** `gs_ready`=1, `gs_dout`=0xFF, `mem_req`=0, `mem_we`=0, `mem_addr`=0, `mem_wdata`=0, `ld_overflow`=0. The FIFO is emptied and the last-served GS tuple is cleared.
- **GS new request:** `gs_rd|gs_wr` is high, and either it was low in the previous cycle, or {`gs_rd`,`gs_wr`,`gs_addr`,`gs_din`} differs from the last-served tuple. A held, unchanged request is served once.
- **Out of range:**
  - `mem_size`=0 and `gs_addr[20:19]`≠0.
  - `mem_size`=1 and `gs_addr[20]`=1.
  - `mem_size`=2/3: every address is in range.
- **Loader FIFO:** `ld_wr` pushes {`ld_addr`,`ld_data`}. A push while full and not popping in the same cycle is dropped and sets `ld_overflow`. A push and pop in the same cycle when full is accepted. Loader writes ignore the size mask.
- **FSM states:** IDLE, GS_ACC, LD_ACC.
- **IDLE**, evaluated in priority order:
  1. FIFO not empty: pop the head, load `mem_*` with `mem_we`=1, assert `mem_req`, go to LD_ACC. A pending GS request remains pending.
  2. Else, GS new request out of range: latch the tuple, `gs_ready`←0 for exactly one cycle, then `gs_ready`←1 with `gs_dout`←0xFF for a read. No `mem_req`. Stay in IDLE.
  3. Else, GS new request in range: latch the tuple, `gs_ready`←0, load `mem_*` (`mem_we`=`gs_wr`), assert `mem_req`, go to GS_ACC.
- **GS_ACC:** on `mem_ack`, `mem_req`←0, `gs_ready`←1, `gs_dout`←`mem_rdata` for a read (unchanged for a write), go to IDLE.
- **LD_ACC:** on `mem_ack`, `mem_req`←0, go to IDLE.
- **Pending GS request:** while a GS new request is waiting behind loader traffic, `gs_ready` is 0 from the cycle after it appears.
- **Reset mid-access:** the next cycle shows reset values. An in-flight `mem_ack` arriving after reset is ignored.

## Timing
- **GS request latency:** GS request sampled at edge N → `gs_ready`=0 and `mem_req`=1 from N+1. `mem_ack` sampled at edge M → `mem_req`=0, `gs_ready`=1 and `gs_dout` valid from M+1. Minimum is M=N+1, so `gs_ready` returns at N+2.
- **Out-of-range GS access:** `gs_ready` is low during N+1 only.
- **Loader latency:** push at edge N → `mem_req`=1 from N+1 when IDLE.
- **Back-to-back accesses:** `mem_req` is low for at least one cycle between accesses (ack cycle → IDLE → issue).
- **`mem_req` hold:** `mem_req` never drops without `mem_ack` except on `reset`.

## Test plan
- **Reset:** assert `reset` 2 cycles → all outputs at reset values, FIFO empty.
- **GS in-range read:** `mem_size`=2, `gs_rd` at 0x1ABCD, `mem_ack` 3 cycles after `mem_req`, `mem_rdata`=0x5A → `mem_we`=0, `mem_addr`=0x1ABCD, `gs_ready` low 4 cycles, then `gs_dout`=0x5A. Holding `gs_rd` unchanged issues no second `mem_req`.
- **Out-of-range access:** `mem_size`=0, read 0x080000 → no `mem_req`, `gs_ready` low 1 cycle, `gs_dout`=0xFF. Write 0x100000 with `mem_size`=1 → no `mem_req`.
- **Loader priority:** 3 loader writes (0x000000/0x11, 0x000001/0x22, 0x000002/0x33) plus a simultaneous GS read of 0x000010, ack delay 2 → three writes issued in order, then the GS read. `gs_ready` stays low throughout.
- **Overflow:** depth 4, 6 back-to-back `ld_wr` with `mem_ack` held low → write 1 in flight, writes 2–5 queued, write 6 dropped, `ld_overflow`=1 and sticky. After acks, exactly 5 writes are issued.
- **Reset mid-access:** `reset` while `mem_req`=1 in GS_ACC → next cycle `mem_req`=0, `gs_ready`=1. A late `mem_ack` changes nothing.

Source files
------------

// File: rtl/gs_mem_arb.sv
// General Sound memory port arbiter: shares one byte-wide request/ack memory port between
// the GS Z80 and the data_io loader FIFO, and applies the GS memory-size mask.
module gs_mem_arb #(
    parameter int ADDR_W        = 21,
    parameter int LD_FIFO_DEPTH = 4
) (
    input  logic              clk_sys,
    input  logic              reset,
    input  logic [1:0]        mem_size,
    input  logic [ADDR_W-1:0] gs_addr,
    input  logic [7:0]        gs_din,
    input  logic              gs_rd,
    input  logic              gs_wr,
    output logic [7:0]        gs_dout,
    output logic              gs_ready,
    input  logic              ld_wr,
    input  logic [ADDR_W-1:0] ld_addr,
    input  logic [7:0]        ld_data,
    output logic              ld_overflow,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [7:0]        mem_wdata,
    input  logic [7:0]        mem_rdata,
    input  logic              mem_ack
);

    localparam int PTR_W = (LD_FIFO_DEPTH > 1) ? $clog2(LD_FIFO_DEPTH) : 1;
    localparam int CNT_W = PTR_W + 1;
    localparam int ENT_W = ADDR_W + 8;
    localparam int TUP_W = ADDR_W + 10;
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(LD_FIFO_DEPTH);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_GS_ACC = 2'd1,
        ST_LD_ACC = 2'd2
    } state_t;

    function automatic logic addr_oor(input logic [1:0] size, input logic [1:0] top);
        logic oor;
        case (size)
            2'd0:    oor = (top != 2'b00);
            2'd1:    oor = top[1];
            default: oor = 1'b0;
        endcase
        return oor;
    endfunction

    state_t            state_q, state_d;
    logic              mem_req_q, mem_req_d;
    logic              mem_we_q, mem_we_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic [7:0]        mem_wdata_q, mem_wdata_d;
    logic              gs_ready_q, gs_ready_d;
    logic [7:0]        gs_dout_q, gs_dout_d;
    logic              ld_overflow_q, ld_overflow_d;
    logic [TUP_W-1:0]  last_tup_q, last_tup_d;
    logic              gs_req_prev_q, gs_req_prev_d;
    logic              gs_pend_q, gs_pend_d;
    logic              oor_pend_q, oor_pend_d;
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [ENT_W-1:0]  fifo_mem [LD_FIFO_DEPTH];

    logic              gs_req_s, gs_new_s, gs_want_s, gs_oor_s, gs_served_s;
    logic [TUP_W-1:0]  gs_tup_s;
    logic              fifo_has_s, fifo_pop_s, fifo_full_s, fifo_byp_s;
    logic              fifo_acc_s, fifo_wr_s, fifo_rd_s;
    logic [ENT_W-1:0]  head_s;

    // GS request qualification: a held, unchanged request is served only once
    always_comb begin
        gs_req_s  = gs_rd | gs_wr;
        gs_tup_s  = {gs_rd, gs_wr, gs_addr, gs_din};
        gs_new_s  = gs_req_s & (~gs_req_prev_q | (gs_tup_s != last_tup_q));
        gs_want_s = gs_new_s | (gs_pend_q & gs_req_s);
        gs_oor_s  = addr_oor(mem_size, gs_addr[20:19]);
        fifo_has_s = (cnt_q != {CNT_W{1'b0}}) | ld_wr;
        if (cnt_q != {CNT_W{1'b0}}) begin
            head_s = fifo_mem[rd_ptr_q];
        end else begin
            head_s = {ld_addr, ld_data};
        end
    end

    // Sequencer next state: loader first, then GS (masked or real access)
    always_comb begin
        state_d     = state_q;
        mem_req_d   = mem_req_q;
        mem_we_d    = mem_we_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        gs_ready_d  = gs_ready_q;
        gs_dout_d   = gs_dout_q;
        last_tup_d  = last_tup_q;
        oor_pend_d  = 1'b0;
        fifo_pop_s  = 1'b0;
        gs_served_s = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (oor_pend_q) begin
                    gs_ready_d = 1'b1;
                    gs_dout_d  = last_tup_q[TUP_W-1] ? 8'hFF : gs_dout_q;
                end else begin
                    gs_ready_d = gs_ready_q;
                end
                if (fifo_has_s) begin
                    fifo_pop_s  = 1'b1;
                    mem_req_d   = 1'b1;
                    mem_we_d    = 1'b1;
                    mem_addr_d  = head_s[ENT_W-1:8];
                    mem_wdata_d = head_s[7:0];
                    state_d     = ST_LD_ACC;
                    gs_ready_d  = gs_want_s ? 1'b0 : (oor_pend_q | gs_ready_q);
                end else if (gs_want_s && gs_oor_s) begin
                    // Masked access: one wait cycle, no memory cycle
                    last_tup_d  = gs_tup_s;
                    gs_served_s = 1'b1;
                    gs_ready_d  = 1'b0;
                    oor_pend_d  = 1'b1;
                end else if (gs_want_s) begin
                    last_tup_d  = gs_tup_s;
                    gs_served_s = 1'b1;
                    gs_ready_d  = 1'b0;
                    mem_req_d   = 1'b1;
                    mem_we_d    = gs_wr;
                    mem_addr_d  = gs_addr;
                    mem_wdata_d = gs_din;
                    state_d     = ST_GS_ACC;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_GS_ACC: begin
                if (mem_ack) begin
                    mem_req_d  = 1'b0;
                    gs_ready_d = 1'b1;
                    gs_dout_d  = mem_we_q ? gs_dout_q : mem_rdata;
                    state_d    = ST_IDLE;
                end else begin
                    mem_req_d = 1'b1;
                end
            end
            ST_LD_ACC: begin
                gs_ready_d = gs_want_s ? 1'b0 : gs_ready_q;
                if (mem_ack) begin
                    mem_req_d = 1'b0;
                    state_d   = ST_IDLE;
                end else begin
                    mem_req_d = 1'b1;
                end
            end
            default: begin
                state_d    = ST_IDLE;
                mem_req_d  = 1'b0;
                gs_ready_d = 1'b1;
            end
        endcase
    end

    // GS pending tracking and loader FIFO bookkeeping (empty FIFO with a pop bypasses storage)
    always_comb begin
        gs_req_prev_d = gs_req_s;
        if (!gs_req_s) begin
            gs_pend_d = 1'b0;
        end else if (gs_served_s) begin
            gs_pend_d = 1'b0;
        end else if (gs_new_s) begin
            gs_pend_d = 1'b1;
        end else begin
            gs_pend_d = gs_pend_q;
        end
        fifo_full_s   = (cnt_q == FULL_CNT);
        fifo_byp_s    = fifo_pop_s & (cnt_q == {CNT_W{1'b0}});
        fifo_acc_s    = ld_wr & (~fifo_full_s | fifo_pop_s);
        fifo_wr_s     = fifo_acc_s & ~fifo_byp_s;
        fifo_rd_s     = fifo_pop_s & ~fifo_byp_s;
        ld_overflow_d = ld_overflow_q | (ld_wr & ~fifo_acc_s);
        if (fifo_wr_s) begin
            wr_ptr_d = wr_ptr_q + PTR_W'(1);
        end else begin
            wr_ptr_d = wr_ptr_q;
        end
        if (fifo_rd_s) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end else begin
            rd_ptr_d = rd_ptr_q;
        end
        cnt_d = cnt_q + CNT_W'(fifo_wr_s) - CNT_W'(fifo_rd_s);
    end

    // FIFO storage write port
    always_ff @(posedge clk_sys) begin
        if (fifo_wr_s) begin
            fifo_mem[wr_ptr_q] <= {ld_addr, ld_data};
        end
    end

    // State and output registers
    always_ff @(posedge clk_sys) begin
        if (reset) begin
            state_q       <= ST_IDLE;
            mem_req_q     <= 1'b0;
            mem_we_q      <= 1'b0;
            mem_addr_q    <= {ADDR_W{1'b0}};
            mem_wdata_q   <= 8'h00;
            gs_ready_q    <= 1'b1;
            gs_dout_q     <= 8'hFF;
            ld_overflow_q <= 1'b0;
            last_tup_q    <= {TUP_W{1'b0}};
            gs_req_prev_q <= 1'b0;
            gs_pend_q     <= 1'b0;
            oor_pend_q    <= 1'b0;
            wr_ptr_q      <= {PTR_W{1'b0}};
            rd_ptr_q      <= {PTR_W{1'b0}};
            cnt_q         <= {CNT_W{1'b0}};
        end else begin
            state_q       <= state_d;
            mem_req_q     <= mem_req_d;
            mem_we_q      <= mem_we_d;
            mem_addr_q    <= mem_addr_d;
            mem_wdata_q   <= mem_wdata_d;
            gs_ready_q    <= gs_ready_d;
            gs_dout_q     <= gs_dout_d;
            ld_overflow_q <= ld_overflow_d;
            last_tup_q    <= last_tup_d;
            gs_req_prev_q <= gs_req_prev_d;
            gs_pend_q     <= gs_pend_d;
            oor_pend_q    <= oor_pend_d;
            wr_ptr_q      <= wr_ptr_d;
            rd_ptr_q      <= rd_ptr_d;
            cnt_q         <= cnt_d;
        end
    end

    assign mem_req     = mem_req_q;
    assign mem_we      = mem_we_q;
    assign mem_addr    = mem_addr_q;
    assign mem_wdata   = mem_wdata_q;
    assign gs_ready    = gs_ready_q;
    assign gs_dout     = gs_dout_q;
    assign ld_overflow = ld_overflow_q;

endmodule

// File: tb/tb_gs_mem_arb.sv
// Self-checking bench for gs_mem_arb: directed vector table, multi-cycle corner sequences,
// and randomized traffic against a transaction-level memory model.
module tb_gs_mem_arb;

    logic        clk_sys = 1'b0;
    logic        reset;
    logic [1:0]  mem_size;
    logic [20:0] gs_addr;
    logic [7:0]  gs_din;
    logic        gs_rd, gs_wr;
    logic [7:0]  gs_dout;
    logic        gs_ready;
    logic        ld_wr;
    logic [20:0] ld_addr;
    logic [7:0]  ld_data;
    logic        ld_overflow;
    logic        mem_req, mem_we;
    logic [20:0] mem_addr;
    logic [7:0]  mem_wdata, mem_rdata;
    logic        mem_ack;

    always #5 clk_sys = ~clk_sys;

    gs_mem_arb #(.ADDR_W(21), .LD_FIFO_DEPTH(4)) dut (
        .clk_sys(clk_sys), .reset(reset), .mem_size(mem_size),
        .gs_addr(gs_addr), .gs_din(gs_din), .gs_rd(gs_rd), .gs_wr(gs_wr),
        .gs_dout(gs_dout), .gs_ready(gs_ready),
        .ld_wr(ld_wr), .ld_addr(ld_addr), .ld_data(ld_data), .ld_overflow(ld_overflow),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .mem_ack(mem_ack)
    );

    typedef struct {
        logic        we;
        logic [20:0] addr;
        logic [7:0]  data;
    } tx_t;

    typedef struct {
        logic [1:0]  size;
        logic        rd;
        logic [20:0] addr;
        logic [7:0]  din;
        int          dly;
        int          exp_mem;
        int          exp_low;
        logic [7:0]  exp_dout;
    } vec_t;

    int          errs = 0;
    int          checks = 0;
    tx_t         txlog[$];
    logic [7:0]  mem_arr [int];
    logic [7:0]  ref_mem [int];
    int          ack_dly = 1;
    bit          ack_en = 1'b1;
    bit          late_ack = 1'b0;
    int          ack_cnt = 0;
    logic        prev_req = 1'b0;
    logic [29:0] prev_bus = 30'd0;
    vec_t        vt[12];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic chk_tx(input string name, input int idx, input logic we, input logic [20:0] a,
                          input logic [7:0] d, input bit cmp_data);
        if (idx < txlog.size()) begin
            chk(name, {txlog[idx].we, txlog[idx].addr, cmp_data ? txlog[idx].data : 8'h00},
                {we, a, cmp_data ? d : 8'h00});
        end else begin
            chk({name, "_missing"}, txlog.size(), idx + 1);
        end
    endtask

    // One clock: protocol checks on the bus, then the memory responder acts for the next edge
    task automatic tick();
        logic acked;
        int   a;
        @(negedge clk_sys);
        acked = mem_ack;
        if (prev_req && !reset) begin
            if (!acked) chk("req_hold", {mem_req, mem_we, mem_addr, mem_wdata}, {1'b1, prev_bus});
            else        chk("req_gap", {31'd0, mem_req}, 32'd0);
        end
        mem_ack = 1'b0;
        if (late_ack) begin
            mem_ack   = 1'b1;
            mem_rdata = 8'h3C;
            late_ack  = 1'b0;
        end else if (mem_req && ack_en && !acked) begin
            ack_cnt++;
            if (ack_cnt >= ack_dly) begin
                a = int'(mem_addr);
                mem_ack   = 1'b1;
                mem_rdata = mem_arr.exists(a) ? mem_arr[a] : 8'h00;
                if (mem_we) mem_arr[a] = mem_wdata;
                txlog.push_back('{mem_we, mem_addr, mem_wdata});
                ack_cnt = 0;
            end
        end else if (!mem_req) begin
            ack_cnt = 0;
        end
        prev_req = mem_req;
        prev_bus = {mem_we, mem_addr, mem_wdata};
    endtask

    // One GS access from request to completion, then a held-request idle window
    task automatic gs_op(input string name, input logic [1:0] size, input logic rd,
                         input logic [20:0] a, input logic [7:0] din, input int dly,
                         input int exp_mem, input int exp_low, input logic [7:0] exp_dout);
        int base = txlog.size();
        int low = 0;
        int n = 0;
        bit done = 1'b0;
        bit saw_req = 1'b0;
        bit saw_wait = 1'b0;
        ack_dly = dly; mem_size = size;
        gs_rd = rd; gs_wr = ~rd; gs_addr = a; gs_din = din;
        while (!done && n < 100) begin
            tick(); n++;
            if (!gs_ready) low++;
            else if (low > 0) done = 1'b1;
        end
        chk({name, "_done"}, {31'd0, done}, 32'd1);
        chk({name, "_low"}, low, exp_low);
        chk({name, "_memcyc"}, txlog.size() - base, exp_mem);
        if (exp_mem > 0) chk_tx({name, "_bus"}, base, ~rd, a, din, ~rd);
        if (rd) chk({name, "_dout"}, {24'd0, gs_dout}, {24'd0, exp_dout});
        repeat (3) begin
            tick();
            if (mem_req) saw_req = 1'b1;
            if (!gs_ready) saw_wait = 1'b1;
        end
        chk({name, "_held_once"}, {30'd0, saw_req, saw_wait}, 32'd0);
        gs_rd = 1'b0; gs_wr = 1'b0;
        tick();
    endtask

    function automatic logic [20:0] rand_addr();
        logic [20:0] hi, lo;
        hi = 21'($urandom_range(0, 3));
        lo = 21'($urandom_range(0, 7));
        return (hi << 19) | lo;
    endfunction

    initial begin
        int base, n, lim, len;
        bit early, oor, rd;
        logic [1:0]  sz;
        logic [20:0] a;
        logic [7:0]  d, expd;
        logic [7:0]  ldv[3];
        tx_t         expq[$];

        vt[0]  = '{2'd2, 1'b0, 21'h01ABCD, 8'h5A, 1, 1, 1, 8'h00};
        vt[1]  = '{2'd2, 1'b1, 21'h01ABCD, 8'h00, 4, 1, 4, 8'h5A};
        vt[2]  = '{2'd0, 1'b1, 21'h080000, 8'h00, 1, 0, 1, 8'hFF};
        vt[3]  = '{2'd1, 1'b0, 21'h100000, 8'h77, 1, 0, 1, 8'h00};
        vt[4]  = '{2'd0, 1'b0, 21'h07FFFF, 8'hC3, 2, 1, 2, 8'h00};
        vt[5]  = '{2'd0, 1'b1, 21'h07FFFF, 8'h00, 1, 1, 1, 8'hC3};
        vt[6]  = '{2'd1, 1'b1, 21'h100000, 8'h00, 1, 0, 1, 8'hFF};
        vt[7]  = '{2'd3, 1'b1, 21'h100000, 8'h00, 2, 1, 2, 8'h00};
        vt[8]  = '{2'd2, 1'b0, 21'h180000, 8'h99, 3, 1, 3, 8'h00};
        vt[9]  = '{2'd1, 1'b1, 21'h180000, 8'h00, 1, 0, 1, 8'hFF};
        vt[10] = '{2'd2, 1'b1, 21'h180000, 8'h00, 1, 1, 1, 8'h99};
        vt[11] = '{2'd1, 1'b1, 21'h0FFFFF, 8'h00, 2, 1, 2, 8'h00};

        reset = 1'b1; mem_size = 2'd2; gs_addr = 21'd0; gs_din = 8'd0; gs_rd = 1'b0; gs_wr = 1'b0;
        ld_wr = 1'b0; ld_addr = 21'd0; ld_data = 8'd0; mem_rdata = 8'd0; mem_ack = 1'b0;

        // Reset state
        tick(); tick();
        chk("rst_outputs", {gs_ready, mem_req, mem_we, ld_overflow, gs_dout, mem_wdata},
            {1'b1, 1'b0, 1'b0, 1'b0, 8'hFF, 8'h00});
        chk("rst_addr", {11'd0, mem_addr}, 32'd0);
        reset = 1'b0;
        tick();

        // Directed vector table
        for (int i = 0; i < 12; i++) begin
            gs_op($sformatf("vec%0d", i), vt[i].size, vt[i].rd, vt[i].addr, vt[i].din,
                  vt[i].dly, vt[i].exp_mem, vt[i].exp_low, vt[i].exp_dout);
            if (vt[i].exp_mem > 0 && !vt[i].rd) ref_mem[int'(vt[i].addr)] = vt[i].din;
        end

        // Loader priority over a simultaneous GS read
        ldv[0] = 8'h11; ldv[1] = 8'h22; ldv[2] = 8'h33;
        base = txlog.size(); ack_dly = 2; mem_size = 2'd2; early = 1'b0;
        for (int i = 0; i < 3; i++) begin
            ld_wr = 1'b1; ld_addr = 21'(i); ld_data = ldv[i];
            if (i == 0) begin gs_rd = 1'b1; gs_addr = 21'h000010; end
            tick();
            if (gs_ready) early = 1'b1;
            ref_mem[i] = ldv[i];
        end
        ld_wr = 1'b0;
        n = 0;
        while (txlog.size() < base + 4 && n < 100) begin
            tick(); n++;
            if (gs_ready && txlog.size() < base + 4) early = 1'b1;
        end
        tick();
        chk("prio_ready_low", {31'd0, early}, 32'd0);
        chk("prio_ready_back", {31'd0, gs_ready}, 32'd1);
        for (int i = 0; i < 3; i++) chk_tx($sformatf("prio_ld%0d", i), base + i, 1'b1, 21'(i), ldv[i], 1'b1);
        chk_tx("prio_gs", base + 3, 1'b0, 21'h000010, 8'h00, 1'b0);
        chk("prio_dout", {24'd0, gs_dout}, 32'd0);
        gs_rd = 1'b0;
        tick(); tick();

        // FIFO overflow with acks held off
        base = txlog.size(); ack_en = 1'b0;
        for (int i = 0; i < 6; i++) begin
            ld_wr = 1'b1; ld_addr = 21'h40 + 21'(i); ld_data = 8'hA0 + 8'(i);
            tick();
            if (i == 4) chk("ovf_not_yet", {31'd0, ld_overflow}, 32'd0);
        end
        ld_wr = 1'b0;
        chk("ovf_set", {31'd0, ld_overflow}, 32'd1);
        ack_en = 1'b1; ack_dly = 1;
        repeat (40) tick();
        chk("ovf_sticky", {31'd0, ld_overflow}, 32'd1);
        chk("ovf_count", txlog.size() - base, 5);
        for (int i = 0; i < 5; i++) begin
            chk_tx($sformatf("ovf_wr%0d", i), base + i, 1'b1, 21'h40 + 21'(i), 8'hA0 + 8'(i), 1'b1);
            ref_mem[32'h40 + i] = 8'hA0 + 8'(i);
        end

        // Reset during a GS access, followed by a stale ack
        ack_en = 1'b0; mem_size = 2'd2; gs_rd = 1'b1; gs_addr = 21'h01ABCD;
        tick(); tick();
        chk("midrst_inflight", {30'd0, mem_req, gs_ready}, 32'd2);
        reset = 1'b1; gs_rd = 1'b0;
        tick();
        reset = 1'b0;
        chk("midrst_state", {gs_ready, mem_req, ld_overflow, gs_dout}, {1'b1, 1'b0, 1'b0, 8'hFF});
        base = txlog.size(); late_ack = 1'b1;
        repeat (3) tick();
        chk("late_ack_ignored", {gs_ready, mem_req, gs_dout}, {1'b1, 1'b0, 8'hFF});
        ack_en = 1'b1;

        // Randomized traffic against the reference memory model
        for (int it = 0; it < 60; it++) begin
            if ($urandom_range(0, 3) == 0) begin
                len = $urandom_range(1, 4); ack_dly = $urandom_range(1, 2);
                base = txlog.size(); expq.delete();
                for (int j = 0; j < len; j++) begin
                    a = rand_addr(); d = 8'($urandom);
                    ld_wr = 1'b1; ld_addr = a; ld_data = d;
                    tick();
                    ref_mem[int'(a)] = d;
                    expq.push_back('{1'b1, a, d});
                end
                ld_wr = 1'b0;
                n = 0;
                while (txlog.size() < base + len && n < 100) begin tick(); n++; end
                chk($sformatf("rnd%0d_drain", it), txlog.size() - base, len);
                for (int j = 0; j < len; j++)
                    chk_tx($sformatf("rnd%0d_ld%0d", it, j), base + j, 1'b1, expq[j].addr, expq[j].data, 1'b1);
                tick();
            end else begin
                sz = 2'($urandom_range(0, 3)); rd = 1'($urandom_range(0, 1));
                a = rand_addr(); d = 8'($urandom); n = $urandom_range(1, 3);
                lim = (sz == 2'd0) ? (1 << 19) : (sz == 2'd1) ? (1 << 20) : (1 << 21);
                oor = (int'(a) >= lim);
                expd = oor ? 8'hFF : (ref_mem.exists(int'(a)) ? ref_mem[int'(a)] : 8'h00);
                gs_op($sformatf("rnd%0d", it), sz, rd, a, d, n, oor ? 0 : 1, oor ? 1 : n, expd);
                if (!rd && !oor) ref_mem[int'(a)] = d;
            end
        end

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule
